// File: rtl/seg_operand_decoder.sv
// seg_operand_decoder: turns two active-low seven-segment digits (tens, ones) into a 5-bit operand
module seg_operand_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_val,
    output logic       in_rdy,
    input  logic [6:0] in_seg,
    output logic       out_val,
    input  logic       out_rdy,
    output logic [4:0] out_value,
    output logic       out_err
);
    typedef enum logic [1:0] {TENS, ONES, RESULT} state_t;
    state_t state, state_nxt;
    logic [3:0] tens, ones;
    logic       tens_bad, ones_bad;
    logic [4:0] dec;
    logic [6:0] value;
    logic       err;
    // {invalid, digit}; unknown patterns report invalid with digit 0
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b100_0000: decode = 5'd0;
            7'b111_1001: decode = 5'd1;
            7'b010_0100: decode = 5'd2;
            7'b011_0000: decode = 5'd3;
            7'b001_1001: decode = 5'd4;
            7'b001_0010: decode = 5'd5;
            7'b000_0010: decode = 5'd6;
            7'b111_1000: decode = 5'd7;
            7'b000_0000: decode = 5'd8;
            7'b001_0000: decode = 5'd9;
            default:     decode = 5'h10;
        endcase
    endfunction
    assign dec   = decode(in_seg);
    assign value = 7'(tens) * 7'd10 + 7'(ones);
    assign err   = tens_bad | ones_bad | (value > 7'd31);
    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= TENS;
        else        state <= state_nxt;
    end
    // latch each digit and its invalid flag as it is accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tens     <= 4'd0;
            ones     <= 4'd0;
            tens_bad <= 1'b0;
            ones_bad <= 1'b0;
        end else if (in_val && state == TENS) begin
            tens     <= dec[3:0];
            tens_bad <= dec[4];
        end else if (in_val && state == ONES) begin
            ones     <= dec[3:0];
            ones_bad <= dec[4];
        end
    end
    // next state and outputs, all decoded from state and latched digits
    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b1;
        out_val   = 1'b0;
        out_value = 5'd0;
        out_err   = 1'b0;
        case (state)
            TENS:    state_nxt = in_val ? ONES : TENS;
            ONES:    state_nxt = in_val ? RESULT : ONES;
            RESULT: begin
                in_rdy    = 1'b0;
                out_val   = 1'b1;
                out_err   = err;
                out_value = err ? 5'd0 : value[4:0];
                state_nxt = out_rdy ? TENS : RESULT;
            end
            default: state_nxt = TENS;
        endcase
    end
endmodule

// File: tb/tb_seg_operand_decoder.sv
// tb_seg_operand_decoder: directed checks of the seven-segment operand decoder
module tb_seg_operand_decoder;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_val;
    logic       in_rdy;
    logic [6:0] in_seg;
    logic       out_val;
    logic       out_rdy;
    logic [4:0] out_value;
    logic       out_err;
    int         errors = 0;
    int         checks = 0;

    seg_operand_decoder dut (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_seg(in_seg),
        .out_val(out_val), .out_rdy(out_rdy), .out_value(out_value), .out_err(out_err)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_out(input string tag);
        chk({tag, " in_rdy"}, in_rdy, 1);
        chk({tag, " out_val"}, out_val, 0);
        chk({tag, " out_value"}, out_value, 0);
        chk({tag, " out_err"}, out_err, 0);
    endtask

    task automatic send(input logic [6:0] s);
        in_val = 1'b1;
        in_seg = s;
        @(posedge clk);
        #1;
        in_val = 1'b0;
    endtask

    task automatic pair(input string tag, input logic [6:0] t, input logic [6:0] o,
                        input logic [4:0] v, input logic e);
        out_rdy = 1'b1;
        send(t);
        idle_out({tag, " after tens"});
        send(o);
        chk({tag, " out_val"}, out_val, 1);
        chk({tag, " in_rdy"}, in_rdy, 0);
        chk({tag, " out_value"}, out_value, v);
        chk({tag, " out_err"}, out_err, e);
        @(posedge clk);
        #1;
        idle_out({tag, " consumed"});
    endtask

    initial begin
        reset   = 1'b0;
        in_val  = 1'b0;
        in_seg  = 7'h7f;
        out_rdy = 1'b0;
        #12;
        idle_out("reset");
        reset = 1'b1;

        pair("zero_one", 7'b100_0000, 7'b111_1001, 5'd1, 1'b0);
        pair("thirty_one", 7'b011_0000, 7'b111_1001, 5'd31, 1'b0);
        pair("thirty_two", 7'b011_0000, 7'b010_0100, 5'd0, 1'b1);
        pair("bad_tens", 7'b111_1111, 7'b100_0000, 5'd0, 1'b1);
        pair("ninety_nine", 7'b001_0000, 7'b001_0000, 5'd0, 1'b1);
        pair("twenty_six", 7'b010_0100, 7'b000_0010, 5'd26, 1'b0);
        pair("bad_ones", 7'b000_0000, 7'b000_0001, 5'd0, 1'b1);
        pair("fourteen", 7'b111_1001, 7'b001_1001, 5'd14, 1'b0);

        // hold the result with out_rdy low while the input side keeps offering digits
        out_rdy = 1'b0;
        send(7'b100_0000);
        send(7'b001_0010);
        in_val = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_seg = (i % 2 == 0) ? 7'b111_1001 : 7'b000_0000;
            @(posedge clk);
            #1;
            chk("hold out_val", out_val, 1);
            chk("hold in_rdy", in_rdy, 0);
            chk("hold out_value", out_value, 5);
            chk("hold out_err", out_err, 0);
        end
        in_val  = 1'b0;
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        idle_out("hold released");
        pair("after_hold", 7'b111_1001, 7'b010_0100, 5'd12, 1'b0);

        // gaps between tens and ones
        send(7'b100_0000);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            idle_out("gap");
        end
        send(7'b001_0010);
        chk("gap out_val", out_val, 1);
        chk("gap out_value", out_value, 5);
        chk("gap out_err", out_err, 0);
        @(posedge clk);
        #1;
        idle_out("gap consumed");

        // reset while waiting for ones: partial operand dropped
        send(7'b011_0000);
        #2 reset = 1'b0;
        #1;
        idle_out("reset in ONES");
        #1 reset = 1'b1;
        pair("post_reset_ones", 7'b111_1001, 7'b010_0100, 5'd12, 1'b0);

        // reset while the result is pending: pending operand dropped
        out_rdy = 1'b0;
        send(7'b100_0000);
        send(7'b111_1001);
        chk("pending out_val", out_val, 1);
        #2 reset = 1'b0;
        #1;
        idle_out("reset in RESULT");
        #1 reset = 1'b1;
        pair("post_reset_result", 7'b010_0100, 7'b010_0100, 5'd22, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg_operand_decoder.md
SEG_OPERAND_DECODER -- requirements
Module: seg_operand_decoder

Interface
- No parameters.
- REQ-001: clk  input  1  sole clock; all state updates on rising edge.
- REQ-002: reset  input  1  asynchronous, active-low reset (asserted when 0).
- REQ-003: in_val  input  1  in_seg holds a valid digit pattern this cycle.
- REQ-004: in_rdy  output  1  block can accept a digit this cycle.
- REQ-005: in_seg  input  7  active-low seven-segment digit pattern; bit 6 = g ... bit 0 = a.
- REQ-006: out_val  output  1  decoded operand is available.
- REQ-007: out_rdy  input  1  consumer accepts the operand this cycle.
- REQ-008: out_value  output  5  decoded operand, 0..31.
- REQ-009: out_err  output  1  operand invalid (bad pattern or value > 31).

Function
- REQ-010: Input transfer SHALL occur on a rising edge where in_val=1 and in_rdy=1; output transfer on a rising edge where out_val=1 and out_rdy=1.
- REQ-011: Digits SHALL arrive tens first, then ones; each operand is exactly two transfers.
- REQ-012: Legal patterns SHALL be: 0=100_0000, 1=111_1001, 2=010_0100, 3=011_0000, 4=001_1001, 5=001_0010, 6=000_0010, 7=111_1000, 8=000_0000, 9=001_0000; any other pattern is invalid.
- REQ-013: The FSM SHALL have three states: TENS, ONES, RESULT.
- REQ-014: TENS: in_rdy=1, out_val=0; on input transfer latch the tens digit and its invalid flag, go to ONES; otherwise stay.
- REQ-015: ONES: in_rdy=1, out_val=0; on input transfer latch the ones digit and its invalid flag, go to RESULT; otherwise stay.
- REQ-016: RESULT: in_rdy=0, out_val=1; on output transfer go to TENS; otherwise hold all outputs stable.
- REQ-017: in_val and in_seg SHALL be ignored in RESULT; out_rdy SHALL be ignored outside RESULT.
- REQ-018: The value SHALL be computed at 7-bit width as tens*10 + ones (max 99) before any range check.
- REQ-019: out_err=1 iff either digit was invalid or the 7-bit value exceeds 31.
- REQ-020: out_value SHALL equal value[4:0] when out_err=0, and 5'd0 when out_err=1.
- REQ-021: out_val SHALL rise on the first rising edge after the ones transfer (one-cycle latency); out_value/out_err valid from that same cycle.
- REQ-022: Best-case throughput SHALL be one operand per 3 cycles (TENS, ONES, RESULT with out_rdy=1).
- REQ-023: out_value and out_err SHALL be 0 whenever out_val=0.
- REQ-024: All outputs SHALL be driven from registers or state decode only; no combinational path from in_seg to any output.

Reset
- REQ-025: While reset=0 the FSM SHALL be in TENS, with latched digits and flags cleared, irrespective of clk.
- REQ-026: Reset values: in_rdy=1, out_val=0, out_value=5'd0, out_err=0.
- REQ-027: Reset asserted mid-operand (ONES or RESULT) SHALL discard the partial or pending operand; the next accepted digit after release is a tens digit.

Verification
- REQ-028: tens 100_0000, ones 111_1001, out_rdy=1 -> one cycle after ones transfer out_val=1, out_value=1, out_err=0; next cycle TENS, in_rdy=1.
- REQ-029: tens 011_0000, ones 111_1001 -> out_value=31, out_err=0; then tens 011_0000, ones 010_0100 -> out_value=0, out_err=1.
- REQ-030: tens 111_1111 (invalid), ones 100_0000 -> out_err=1, out_value=0; tens 001_0000, ones 001_0000 (99) -> out_err=1, out_value=0.
- REQ-031: Result ready, out_rdy=0 for 3 cycles while in_val=1 with in_seg toggling -> out_val, out_value, out_err stable, in_rdy=0, no digit consumed; out_rdy=1 -> returns to TENS.
- REQ-032: in_val=0 gaps of 2 cycles between tens and ones -> state held; result for 100_0000, 001_0010 is out_value=5.
- REQ-033: tens accepted, reset pulsed low mid-cycle -> immediately in_rdy=1, out_val=0; next pair 111_1001, 010_0100 -> out_value=12, out_err=0.
